// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the load/store unit (port 0) and
// a debug/DMA engine (port 1); rejects misaligned/illegal accesses and routes read data back.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [2:0]        m0_memop,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [2:0]        m1_memop,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    output logic [2:0]        mem_memop,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dataout
);

    logic last_q, last_d;
    logic resp_valid_q, resp_port_q, resp_load_q, resp_err_q;
    logic req0, req1, any_gnt, sel_we, legal;
    logic hit0, hit1;

    function automatic logic access_legal(input logic we, input logic [2:0] op,
                                          input logic [1:0] lsb);
        logic ok;
        ok = 1'b0;
        case (op)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~lsb[0];
            3'b010:  ok = (lsb == 2'b00);
            3'b100:  ok = ~we;
            3'b101:  ok = ~we & ~lsb[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_comb begin
        // Requests presented while rst is high are ignored outright.
        req0       = m0_req & ~rst;
        req1       = m1_req & ~rst;
        m0_gnt     = req0 & (~req1 | last_q);
        m1_gnt     = req1 & (~req0 | ~last_q);
        any_gnt    = m0_gnt | m1_gnt;
        mem_addr   = '0;
        mem_datain = '0;
        mem_memop  = 3'b000;
        sel_we     = 1'b0;
        if (m0_gnt) begin
            mem_addr   = m0_addr;
            mem_datain = m0_wdata;
            mem_memop  = m0_memop;
            sel_we     = m0_we;
        end else if (m1_gnt) begin
            mem_addr   = m1_addr;
            mem_datain = m1_wdata;
            mem_memop  = m1_memop;
            sel_we     = m1_we;
        end
        legal  = access_legal(sel_we, mem_memop, mem_addr[1:0]);
        mem_we = any_gnt & sel_we & legal;
        last_d = any_gnt ? m1_gnt : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_port_q  <= 1'b0;
            resp_load_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            last_q       <= last_d;
            resp_valid_q <= any_gnt;
            resp_port_q  <= m1_gnt;
            resp_load_q  <= ~sel_we;
            resp_err_q   <= ~legal;
        end
    end

    always_comb begin
        hit0      = resp_valid_q & ~resp_port_q;
        hit1      = resp_valid_q & resp_port_q;
        m0_rvalid = hit0 & resp_load_q;
        m1_rvalid = hit1 & resp_load_q;
        m0_err    = hit0 & resp_err_q;
        m1_err    = hit1 & resp_err_q;
        // Rejected loads still flag rvalid but must not leak memory contents.
        m0_rdata  = (m0_rvalid & ~resp_err_q) ? mem_dataout : '0;
        m1_rdata  = (m1_rvalid & ~resp_err_q) ? mem_dataout : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed table-driven bench for dmem_arbiter with a byte-addressed memory model
// (synchronous one-cycle read, sign/zero extension done by the memory).
module tb_dmem_arbiter;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, BAD = 3'b011;
    localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic        rst;
        req_t        p0;
        req_t        p1;
        logic        g0, g1, mwe;
        logic [31:0] maddr;
        logic        v0, v1, e0, e1;
        logic [31:0] rd0, rd1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    req_t        p0, p1;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_datain, mem_dataout;
    logic [2:0]  mem_memop;
    logic        mem_we;
    logic [7:0]  mem [0:255];

    int total = 0;
    int bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(p0.req), .m0_we(p0.we), .m0_memop(p0.op), .m0_addr(p0.addr),
        .m0_wdata(p0.wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m0_err(m0_err),
        .m1_req(p1.req), .m1_we(p1.we), .m1_memop(p1.op), .m1_addr(p1.addr),
        .m1_wdata(p1.wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_memop(mem_memop),
        .mem_we(mem_we), .mem_dataout(mem_dataout)
    );

    // Memory model: read uses pre-write contents, write commits at the clock edge.
    always @(posedge clk) begin
        logic [7:0] a;
        logic [31:0] rd;
        a = mem_addr[7:0];
        case (mem_memop)
            LB:      rd = {{24{mem[a][7]}}, mem[a]};
            LH:      rd = {{16{mem[a+8'd1][7]}}, mem[a+8'd1], mem[a]};
            LW:      rd = {mem[a+8'd3], mem[a+8'd2], mem[a+8'd1], mem[a]};
            LBU:     rd = {24'h0, mem[a]};
            LHU:     rd = {16'h0, mem[a+8'd1], mem[a]};
            default: rd = 32'hBAADF00D;
        endcase
        mem_dataout <= rd;
        if (mem_we) begin
            mem[a] <= mem_datain[7:0];
            if (mem_memop == LH || mem_memop == LW) mem[a+8'd1] <= mem_datain[15:8];
            if (mem_memop == LW) begin
                mem[a+8'd2] <= mem_datain[23:16];
                mem[a+8'd3] <= mem_datain[31:24];
            end
        end
    end

    function automatic req_t ld(input logic [2:0] op, input logic [31:0] addr);
        return '{req: 1'b1, we: 1'b0, op: op, addr: addr, wdata: 32'h0};
    endfunction

    function automatic req_t st(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata);
        return '{req: 1'b1, we: 1'b1, op: op, addr: addr, wdata: wdata};
    endfunction

    localparam req_t NOP = '{req: 1'b0, we: 1'b0, op: 3'b000, addr: 32'h0, wdata: 32'h0};

    // Expected response fields describe the previous cycle's grant, seen this cycle.
    task automatic add(input logic r, input req_t a, input req_t b, input logic g0,
                       input logic g1, input logic mwe, input logic [31:0] maddr,
                       input logic v0, input logic v1, input logic e0, input logic e1,
                       input logic [31:0] rd0, input logic [31:0] rd1);
        vecs.push_back('{r, a, b, g0, g1, mwe, maddr, v0, v1, e0, e1, rd0, rd1});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check mid-cycle, then move to just after the next edge.
    task automatic run(input vec_t v, input string tag);
        rst = v.rst;
        p0  = v.p0;
        p1  = v.p1;
        #4;
        chk({tag, " m0_gnt"}, {31'h0, m0_gnt}, {31'h0, v.g0});
        chk({tag, " m1_gnt"}, {31'h0, m1_gnt}, {31'h0, v.g1});
        chk({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, v.mwe});
        chk({tag, " mem_addr"}, mem_addr, v.maddr);
        chk({tag, " m0_rvalid"}, {31'h0, m0_rvalid}, {31'h0, v.v0});
        chk({tag, " m1_rvalid"}, {31'h0, m1_rvalid}, {31'h0, v.v1});
        chk({tag, " m0_err"}, {31'h0, m0_err}, {31'h0, v.e0});
        chk({tag, " m1_err"}, {31'h0, m1_err}, {31'h0, v.e1});
        chk({tag, " m0_rdata"}, m0_rdata, v.rd0);
        chk({tag, " m1_rdata"}, m1_rdata, v.rd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hDEADBEEF;
        {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'h11223344;
        rst = 1'b1;
        p0  = NOP;
        p1  = NOP;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Single m0 load, then dual contention after a reset that swallows a request.
        add(0, NOP, NOP, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        add(0, ld(LW, 32'h10), NOP, 1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        add(0, NOP, NOP, 0, 0, 0, 32'h0, 1, 0, 0, 0, 32'hDEADBEEF, 0);
        add(1, ld(LW, 32'h10), NOP, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        add(0, ld(LW, 32'h10), ld(LW, 32'h20), 1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        add(0, ld(LW, 32'h10), ld(LW, 32'h20), 0, 1, 0, 32'h20, 1, 0, 0, 0, 32'hDEADBEEF, 0);
        add(0, ld(LW, 32'h10), ld(LW, 32'h20), 1, 0, 0, 32'h10, 0, 1, 0, 0, 0, 32'h11223344);
        add(0, ld(LW, 32'h10), ld(LW, 32'h20), 0, 1, 0, 32'h20, 1, 0, 0, 0, 32'hDEADBEEF, 0);
        add(0, ld(LW, 32'h10), ld(LW, 32'h20), 1, 0, 0, 32'h10, 0, 1, 0, 0, 0, 32'h11223344);
        add(0, ld(LW, 32'h10), ld(LW, 32'h20), 0, 1, 0, 32'h20, 1, 0, 0, 0, 32'hDEADBEEF, 0);
        add(0, NOP, NOP, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h11223344);
        // m1 sb then m0 lbu same byte.
        add(0, NOP, st(LB, 32'h21, 32'hAB), 0, 1, 1, 32'h21, 0, 0, 0, 0, 0, 0);
        add(0, ld(LBU, 32'h21), NOP, 1, 0, 0, 32'h21, 0, 0, 0, 0, 0, 0);
        add(0, NOP, NOP, 0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h000000AB, 0);
        // Misaligned sw and illegal memop load.
        add(0, ld(LW, 32'h20), NOP, 1, 0, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        add(0, st(LW, 32'h22, 32'h12345678), NOP, 1, 0, 0, 32'h22, 1, 0, 0, 0, 32'h1122AB44, 0);
        add(0, NOP, ld(BAD, 32'h20), 0, 1, 0, 32'h20, 0, 0, 1, 0, 0, 0);
        add(0, ld(LW, 32'h20), NOP, 1, 0, 0, 32'h20, 0, 1, 0, 1, 0, 0);
        // Back-to-back sw / lw to the same word.
        add(0, st(LW, 32'h30, 32'h55AA55AA), NOP, 1, 0, 1, 32'h30, 1, 0, 0, 0, 32'h1122AB44, 0);
        add(0, ld(LW, 32'h30), NOP, 1, 0, 0, 32'h30, 0, 0, 0, 0, 0, 0);
        add(0, NOP, NOP, 0, 0, 0, 32'h0, 1, 0, 0, 0, 32'h55AA55AA, 0);
        // Halfword alignment, sign/zero extension routing, store with load-only memop.
        add(0, NOP, ld(LH, 32'h11), 0, 1, 0, 32'h11, 0, 0, 0, 0, 0, 0);
        add(0, NOP, ld(LHU, 32'h12), 0, 1, 0, 32'h12, 0, 1, 0, 1, 0, 0);
        add(0, ld(LB, 32'h13), NOP, 1, 0, 0, 32'h13, 0, 1, 0, 0, 0, 32'h0000DEAD);
        add(0, NOP, st(LBU, 32'h30, 32'hFF), 0, 1, 0, 32'h30, 1, 0, 0, 0, 32'hFFFFFFDE, 0);
        add(0, ld(LH, 32'h12), NOP, 1, 0, 0, 32'h12, 0, 0, 0, 1, 0, 0);
        add(0, NOP, NOP, 0, 0, 0, 32'h0, 1, 0, 0, 0, 32'hFFFFDEAD, 0);

        for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("vec%0d", i));

        // m0 loses arbitration (last=0) and withdraws: no side effects for m0.
        run('{0, ld(LW, 32'h10), ld(LW, 32'h30), 0, 1, 0, 32'h30, 0, 0, 0, 0, 0, 0}, "wd0");
        run('{0, NOP, NOP, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h55AA55AA}, "wd1");
        run('{0, NOP, NOP, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0}, "wd2");
        // Word 0x20 must still hold the sb result only (rejected sw never landed).
        run('{0, NOP, ld(LW, 32'h20), 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0}, "chk20");
        run('{0, NOP, NOP, 0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 32'h1122AB44}, "chk20r");
        // Reset while a load is granted-eligible: discarded, pointer back to 1.
        run('{1, ld(LW, 32'h10), ld(LW, 32'h20), 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0}, "rst0");
        run('{0, ld(LW, 32'h10), ld(LW, 32'h20), 1, 0, 0, 32'h10, 0, 0, 0, 0, 0, 0}, "rst1");
        run('{0, NOP, NOP, 0, 0, 0, 32'h0, 1, 0, 0, 0, 32'hDEADBEEF, 0}, "rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data-memory port (byte/half/word load-store memory with synchronous one-cycle read) between the CPU load/store unit (port 0) and a debug/DMA engine (port 1). It grants one access per cycle using round-robin, forwards the chosen address/data/memop/write-enable to the memory, and routes the read data back to the correct requester one cycle later. It also detects misaligned or illegal accesses and rejects them: the access gets an error pulse and is never written.

## Interface
- ADDR_W, 32, address width of requester and memory ports
- DATA_W, 32, data width

- clk  in  1  single system clock; memory read and write clocks are tied to it
- rst  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  access request; held stable until granted
- m0_we / m1_we  in  1  1 = store, 0 = load
- m0_memop / m1_memop  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (stores use 000/001/010)
- m0_addr / m1_addr  in  ADDR_W  byte address
- m0_wdata / m1_wdata  in  DATA_W  store data, right-aligned
- m0_gnt / m1_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid / m1_rvalid  out  1  load data valid (registered)
- m0_rdata / m1_rdata  out  DATA_W  load data, valid only with rvalid
- m0_err / m1_err  out  1  one-cycle pulse: accepted access was misaligned or illegal
- mem_addr  out  ADDR_W  to memory addr
- mem_datain  out  DATA_W  to memory datain
- mem_memop  out  3  to memory memop
- mem_we  out  1  to memory we
- mem_dataout  in  DATA_W  from memory, valid one cycle after the address is presented

## Operation
- Round-robin pointer `last`, 1 bit. It holds the last port granted. Reset value is 1, so port 0 wins the first tie.
- Grant rules:
  - Only one request: that port is granted.
  - Both request: the port ≠ `last` is granted.
  - No request: no grant, mem_we=0, mem_addr/datain/memop=0.
- `last` updates on every cycle with a grant.
- Granted port's addr, wdata and memop drive the mem_* outputs directly.
- mem_we = granted port's we AND access legal.
- Legality rules:
  - Memop 011, 110 and 111 are illegal.
  - A store with memop 100 or 101 is illegal.
  - lh, lhu or sh with addr[0]=1 is misaligned.
  - lw or sw with addr[1:0]≠00 is misaligned.
  - Byte accesses are always aligned.
- Response pipeline: registers resp_valid, resp_port, resp_load, resp_err. They capture the grant every cycle.
- Cycle after a granted load:
  - If legal: the granted port's rvalid=1 and rdata=mem_dataout.
  - If illegal: rvalid=1, rdata=0, err=1.
- Cycle after a granted store: rvalid=0. If illegal, err=1 (write suppressed). Otherwise no response.
- The non-responding port always sees rvalid=0, err=0, rdata=0.
- Back-to-back grants every cycle are supported. Throughput is one access per cycle with no bubbles.

## Timing
- Reset (sampled on clk rising edge):
  - `last` becomes 1.
  - Response registers clear.
  - In the following cycle, rvalid, err and rdata are 0 for both ports.
  - During the rst-high cycle itself, gnt is 0 and mem_we is 0 regardless of requests.
- A load granted in the same cycle rst is asserted is discarded: no rvalid afterwards.
- Load latency: gnt in cycle N, rvalid/rdata in cycle N+1.
- Store: the memory commits at the end of cycle N. A load granted in N+1 to the same address returns the new data in N+2.
- Requester must hold req/addr/we/memop/wdata until it sees gnt. It may drop req or issue a new request in the cycle after gnt.
- Sustained dual requests alternate 0,1,0,1… Neither port can be starved beyond one cycle.
- Request withdrawn before grant: legal, no side effects.

## Test plan
- Reset then m0 lw addr=0x10 alone, mem holds 0xDEADBEEF at 0x10. Expect m0_gnt same cycle, m0_rvalid=1 and m0_rdata=0xDEADBEEF next cycle, m1 outputs 0.
- m0 and m1 both request loads continuously for 6 cycles. Expect grants m0,m1,m0,m1,m0,m1, each rvalid on the correct port one cycle after its grant.
- m1 sb addr=0x21 wdata=0xAB, then m0 lbu addr=0x21 in the next cycle. Expect m0_rdata=0x000000AB; other bytes of word 0x20 unchanged.
- m0 sw addr=0x22 wdata=0x12345678. Expect gnt=1, mem_we=0, m0_err=1 next cycle, word 0x20 unchanged. Also m1 load with memop=011: expect m1_rvalid=1, m1_rdata=0, m1_err=1.
- m0 lw granted in cycle N with rst=1 in N. Expect no m0_rvalid in N+1 and `last`=1. Then a simultaneous request must grant m0 first.
- Back-to-back m0 sw 0x30=0x55AA55AA then lw 0x30 in consecutive cycles. Expect rdata=0x55AA55AA two cycles after the store grant.
